control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin execution from IDLE.
REQ-004 SHALL have port step_mode, input, 1 bit: 1 = pause after every executed instruction.
REQ-005 SHALL have port step, input, 1 bit: release one instruction while paused.
REQ-006 SHALL have port opcode, input, 7 bits: opcode field of current instruction-memory word.
REQ-007 SHALL have port alu_zero, input, 1 bit: ALU result == 0.
REQ-008 SHALL have port alu_neg, input, 1 bit: ALU result bit 7.
REQ-009 SHALL have port pc_inc, output, 1 bit: PC += 1 at next edge.
REQ-010 SHALL have port pc_load, output, 1 bit: PC <= literal at next edge.
REQ-011 SHALL have port la, output, 1 bit: load regA from ALU.
REQ-012 SHALL have port lb, output, 1 bit: load regB from ALU.
REQ-013 SHALL have port alu_s, output, 3 bits: ALU operation select.
REQ-014 SHALL have port sb_lit, output, 1 bit: ALU B operand; 1 = literal, 0 = regB.
REQ-015 SHALL have port state, output, 3 bits: current FSM state code.
REQ-016 SHALL have port halted, output, 1 bit: HALT state reached.
REQ-017 SHALL have port instr_count, output, 16 bits: retired-instruction count.

Function
REQ-018 SHALL use state codes IDLE=0, FETCH=1, EXEC=2, PAUSE=3, HALT=4; codes 5-7 unreachable; if entered, next state is IDLE.
REQ-019 IDLE: SHALL go to FETCH on start=1; otherwise stay in IDLE.
REQ-020 FETCH (1 cycle): SHALL capture opcode into internal ir; all control outputs 0; next state is EXEC.
REQ-021 EXEC (1 cycle): SHALL decode ir only, never the live opcode: class=ir[6:4], alu_s=ir[3:1], sb_lit=ir[0].
REQ-022 Class 000: la=1; pc_inc=1. Class 001: lb=1; pc_inc=1.
REQ-023 ALU classes (000, 001) SHALL update internal flags {Z,N} from {alu_zero, alu_neg} at the end of EXEC; no other class alters the flags.
REQ-024 Class 010 (JMP): pc_load=1. Class 011 (JEQ): pc_load=Z, pc_inc=~Z. Class 100 (JLT): pc_load=N, pc_inc=~N.
REQ-025 Classes 101 and 110 (NOP): pc_inc=1 only.
REQ-026 Class 111 (HALT): no PC strobe; next state is HALT.
REQ-027 pc_inc and pc_load SHALL never both be 1; la and lb SHALL never both be 1; every strobe lasts exactly 1 cycle, in EXEC only.
REQ-028 After a non-HALT EXEC: step_mode=1 -> PAUSE, else -> FETCH; step_mode is sampled in the EXEC cycle.
REQ-029 PAUSE: SHALL go to FETCH on step=1; otherwise stay in PAUSE; step is ignored in all other states.
REQ-030 HALT: halted=1; SHALL stay in HALT until rst; start and step are ignored.
REQ-031 start is ignored outside IDLE.
REQ-032 instr_count SHALL increment by 1 at the end of every EXEC, HALT included; wraps 0xFFFF -> 0x0000.
REQ-033 Throughput: 2 cycles per instruction when step_mode=0.

Reset
REQ-034 When rst=1 at an edge: state=IDLE; ir=0; flags Z=N=0; instr_count=0; all outputs 0.
REQ-035 rst SHALL take priority over every other input.
REQ-036 If rst=1 during EXEC, the strobes from that cycle SHALL have no lasting effect inside this block: no flag update and no count increment.

Verification
REQ-037 Reset, then start pulse; opcodes 0x00, 0x00, 0x70 -> states 0,1,2,1,2,1,2,4; la=1 in cycles 3 and 5; halted=1; instr_count=3.
REQ-038 ALU op with alu_zero=1, then JEQ (0x30) -> pc_load=1, pc_inc=0; repeat with alu_zero=0 -> pc_inc=1, pc_load=0.
REQ-039 step_mode=1, opcode 0x50 -> state sequence 1,2,3; holds 3 for 10 cycles with step=0; step pulse -> 1.
REQ-040 Opcode changes between FETCH and EXEC (0x00 -> 0x10) -> la=1, lb=0 (ir used).
REQ-041 rst asserted in EXEC of an ALU op -> next cycle state=0, instr_count=0, flags 0; a following JEQ with alu_zero=1 driven during the JEQ -> pc_inc=1.
REQ-042 Preload 0xFFFF retired instructions, one more EXEC -> instr_count=0x0000; assertion that pc_inc&pc_load and la&lb are never 1 on any cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer: latches an instruction word, then issues
// one cycle of registered PC/register/ALU strobes, with single-step and halt.
module control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic [6:0]  opcode,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        la,
    output logic        lb,
    output logic [2:0]  alu_s,
    output logic        sb_lit,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] CLS_LA   = 3'd0;
    localparam logic [2:0] CLS_LB   = 3'd1;
    localparam logic [2:0] CLS_JMP  = 3'd2;
    localparam logic [2:0] CLS_JEQ  = 3'd3;
    localparam logic [2:0] CLS_JLT  = 3'd4;
    localparam logic [2:0] CLS_NOP5 = 3'd5;
    localparam logic [2:0] CLS_NOP6 = 3'd6;
    localparam logic [2:0] CLS_HALT = 3'd7;

    state_t      state_r;
    logic [6:0]  ir_r;
    logic        z_r;
    logic        n_r;
    logic [3:0]  unused_ir_s;

    // Strobe vector {pc_inc, pc_load, la, lb, alu_s[2:0], sb_lit} for one word.
    function automatic logic [7:0] decode_strobes(input logic [6:0] word,
                                                  input logic       z,
                                                  input logic       n);
        logic inc_v;
        logic load_v;
        logic la_v;
        logic lb_v;
        inc_v  = 1'b0;
        load_v = 1'b0;
        la_v   = 1'b0;
        lb_v   = 1'b0;
        case (word[6:4])
            CLS_LA:   begin la_v = 1'b1; inc_v = 1'b1; end
            CLS_LB:   begin lb_v = 1'b1; inc_v = 1'b1; end
            CLS_JMP:  load_v = 1'b1;
            CLS_JEQ:  begin load_v = z; inc_v = ~z; end
            CLS_JLT:  begin load_v = n; inc_v = ~n; end
            CLS_NOP5: inc_v = 1'b1;
            CLS_NOP6: inc_v = 1'b1;
            CLS_HALT: inc_v = 1'b0;
            default:  inc_v = 1'b0;
        endcase
        return {inc_v, load_v, la_v, lb_v, word[3:1], word[0]};
    endfunction

    assign state       = state_r;
    // Only the class field drives sequencing; the operand bits reach the
    // outputs through the strobes registered at the fetch edge.
    assign unused_ir_s = ir_r[3:0];

    // Sequencer state, instruction register, flags, retire count and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ir_r        <= 7'd0;
            z_r         <= 1'b0;
            n_r         <= 1'b0;
            instr_count <= 16'd0;
            pc_inc      <= 1'b0;
            pc_load     <= 1'b0;
            la          <= 1'b0;
            lb          <= 1'b0;
            alu_s       <= 3'd0;
            sb_lit      <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc_inc  <= 1'b0;
            pc_load <= 1'b0;
            la      <= 1'b0;
            lb      <= 1'b0;
            alu_s   <= 3'd0;
            sb_lit  <= 1'b0;
            halted  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    // EXEC strobes are registered from the very word latched
                    // into ir, so later opcode changes cannot reach them.
                    ir_r <= opcode;
                    {pc_inc, pc_load, la, lb, alu_s, sb_lit} <= decode_strobes(opcode, z_r, n_r);
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    instr_count <= instr_count + 16'd1;
                    if (ir_r[6:4] == CLS_LA || ir_r[6:4] == CLS_LB) begin
                        z_r <= alu_zero;
                        n_r <= alu_neg;
                    end else begin
                        z_r <= z_r;
                        n_r <= n_r;
                    end
                    if (ir_r[6:4] == CLS_HALT) begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                    end else if (step_mode) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_PAUSE: begin
                    if (step) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                    halted  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-plus-random bench for control_sequencer, checked against an
// instruction-level model of the flags, strobes and retire count.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [6:0]  opcode;
    logic        alu_zero;
    logic        alu_neg;
    logic        pc_inc;
    logic        pc_load;
    logic        la;
    logic        lb;
    logic [2:0]  alu_s;
    logic        sb_lit;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] instr_count;

    int          checks   = 0;
    int          failures = 0;

    logic        m_z;
    logic        m_n;
    logic [15:0] m_count;

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .la          (la),
        .lb          (lb),
        .alu_s       (alu_s),
        .sb_lit      (sb_lit),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the mutual-exclusion rules on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("excl_pc", 32'(pc_inc & pc_load), 32'd0);
        chk("excl_ab", 32'(la & lb), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({pc_inc, pc_load, la, lb, alu_s, sb_lit}), 32'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1; start = 1'b1; step = 1'b1; step_mode = 1'b0;
        opcode = 7'($urandom_range(0, 127));
        alu_zero = 1'b0; alu_neg = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk_quiet("rst_strobes");
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        start = 1'b0; step = 1'b0; rst = 1'b0;
        m_z = 1'b0; m_n = 1'b0; m_count = 16'd0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", 32'(state), 32'd1);
    endtask

    // One instruction from the FETCH cycle to the cycle after EXEC.
    task automatic run_instr(input logic [6:0] op, input logic [6:0] exec_op,
                             input logic az, input logic an, input logic smode);
        logic [2:0] cls;
        logic       e_inc;
        logic       e_load;
        cls = op[6:4];
        opcode = op; alu_zero = az; alu_neg = an; step_mode = smode;
        chk("fetch_state", 32'(state), 32'd1);
        chk_quiet("fetch_strobes");
        e_load = (cls == 3'd2) || (cls == 3'd3 && m_z) || (cls == 3'd4 && m_n);
        e_inc  = (cls inside {3'd0, 3'd1, 3'd5, 3'd6}) || (cls == 3'd3 && !m_z) || (cls == 3'd4 && !m_n);
        tick();
        chk("exec_state", 32'(state), 32'd2);
        chk("exec_pc_inc", 32'(pc_inc), 32'(e_inc));
        chk("exec_pc_load", 32'(pc_load), 32'(e_load));
        chk("exec_la", 32'(la), 32'(cls == 3'd0));
        chk("exec_lb", 32'(lb), 32'(cls == 3'd1));
        chk("exec_alu_s", 32'(alu_s), 32'(op[3:1]));
        chk("exec_sb_lit", 32'(sb_lit), 32'(op[0]));
        opcode = exec_op;
        tick();
        if (cls <= 3'd1) begin
            m_z = az;
            m_n = an;
        end
        m_count = m_count + 16'd1;
        chk("retire_count", 32'(instr_count), 32'(m_count));
        chk_quiet("post_exec_strobes");
        if (cls == 3'd7) begin
            chk("halt_state", 32'(state), 32'd4);
            chk("halt_flag", 32'(halted), 32'd1);
        end else begin
            chk("next_state", 32'(state), smode ? 32'd3 : 32'd1);
            chk("not_halted", 32'(halted), 32'd0);
        end
    endtask

    initial begin
        reset_dut();

        // Two loads then HALT: states 0,1,2,1,2,1,2,4.
        chk("idle_state", 32'(state), 32'd0);
        start_pulse();
        run_instr(7'h00, 7'h7F, 1'b0, 1'b0, 1'b0);
        run_instr(7'h00, 7'h7F, 1'b1, 1'b0, 1'b0);
        run_instr(7'h70, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("halt_count3", 32'(instr_count), 32'd3);
        start = 1'b1; step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_hold", 32'(state), 32'd4);
            chk("halt_hold_cnt", 32'(instr_count), 32'd3);
        end
        start = 1'b0; step = 1'b0;

        // JEQ after an ALU result of zero, then after non-zero.
        reset_dut();
        start_pulse();
        run_instr(7'h02, 7'h55, 1'b1, 1'b0, 1'b0);
        run_instr(7'h30, 7'h11, 1'b0, 1'b0, 1'b0);
        run_instr(7'h10, 7'h22, 1'b0, 1'b1, 1'b0);
        run_instr(7'h30, 7'h33, 1'b1, 1'b0, 1'b0);
        run_instr(7'h41, 7'h00, 1'b0, 1'b0, 1'b0);

        // Single-step: pause holds until step.
        run_instr(7'h50, 7'h00, 1'b0, 1'b0, 1'b1);
        step_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_hold", 32'(state), 32'd3);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_release", 32'(state), 32'd1);

        // Opcode changes between FETCH and EXEC: ir governs.
        run_instr(7'h00, 7'h10, 1'b0, 1'b0, 1'b0);

        // Reset in EXEC of an ALU op cancels the flag update and the count.
        opcode = 7'h00; alu_zero = 1'b1; alu_neg = 1'b1;
        tick();
        chk("rstexec_la", 32'(la), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstexec_state", 32'(state), 32'd0);
        chk("rstexec_count", 32'(instr_count), 32'd0);
        chk_quiet("rstexec_strobes");
        m_z = 1'b0; m_n = 1'b0; m_count = 16'd0;
        start_pulse();
        run_instr(7'h30, 7'h00, 1'b1, 1'b1, 1'b0);
        run_instr(7'h40, 7'h00, 1'b1, 1'b1, 1'b0);

        // Randomized instruction stream, with pauses and halts.
        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            logic       sm;
            op = 7'($urandom_range(0, 127));
            if (op[6:4] == 3'd7 && $urandom_range(0, 2) != 0) op[6] = 1'b0;
            sm = 1'($urandom_range(0, 1));
            run_instr(op, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), sm);
            if (op[6:4] == 3'd7) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("rnd_halt_hold", 32'(state), 32'd4);
                reset_dut();
                start_pulse();
            end else if (sm) begin
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    start = 1'($urandom_range(0, 1));
                    tick();
                    chk("rnd_pause", 32'(state), 32'd3);
                end
                start = 1'b0; step = 1'b1;
                tick();
                step = 1'b0;
                chk("rnd_step", 32'(state), 32'd1);
            end
        end

        // Retire count wraps from 0xFFFF to zero.
        run_instr(7'h50, 7'h00, 1'b0, 1'b0, 1'b1);
        force dut.instr_count = 16'hFFFF;
        tick();
        release dut.instr_count;
        m_count = 16'hFFFF;
        tick();
        chk("preload_count", 32'(instr_count), 32'h0000FFFF);
        step_mode = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        run_instr(7'h60, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", 32'(instr_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
